// File: rtl/vga_mem_arbiter_if.sv
// Bus bundle for vga_mem_arbiter: the display read port, the capture write port
// and the sample RAM port. The arbiter uses the slave modport; the requesters and the RAM model use master.
interface vga_mem_arbiter_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 4
);
    logic              h_display;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              rd_deny;
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  h_display, rd_req, rd_addr, wr_req, wr_addr, wr_data, mem_rdata,
        output rd_data, rd_valid, rd_deny, wr_ready, mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output h_display, rd_req, rd_addr, wr_req, wr_addr, wr_data, mem_rdata,
        input  rd_data, rd_valid, rd_deny, wr_ready, mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/vga_mem_arbiter.sv
// Single-port sample RAM arbiter: display reads win during the visible line, buffered captures drain in blanking.
// Defining ARB_STATS_EN adds saturating rd_deny_cnt / wr_stall_cnt outputs.
//
// state | meaning
// BLANK | horizontal blanking seen last cycle: FIFO drains first, reads take leftovers
// DISP  | visible line seen last cycle: reads first, FIFO writes take leftovers
module vga_mem_arbiter #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    vga_mem_arbiter_if.slave    bus
`ifdef ARB_STATS_EN
    ,
    output logic [15:0]         rd_deny_cnt,
    output logic [15:0]         wr_stall_cnt
`endif
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {BLANK = 1'b0, DISP = 1'b1} phase_t;

    phase_t state, state_next;

    logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]  wptr, rptr;
    logic [CNT_W-1:0]  count, count_next;
    logic              wr_ready_q;
    logic              fifo_ne, push, pop;
    logic              gnt_rd, gnt_wr;
    logic              rd_pend, rd_valid_q;
    logic [DATA_W-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= BLANK;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            BLANK:   if (bus.h_display)  state_next = DISP;
            DISP:    if (!bus.h_display) state_next = BLANK;
            default: state_next = BLANK;
        endcase
    end

    // Grants are forced low while reset is asserted so the RAM is never touched.
    always_comb begin
        gnt_rd = 1'b0;
        gnt_wr = 1'b0;
        if (rst_n) begin
            case (state)
                DISP: begin
                    gnt_rd = bus.rd_req;
                    gnt_wr = !bus.rd_req && fifo_ne;
                end
                default: begin
                    gnt_wr = fifo_ne;
                    gnt_rd = bus.rd_req && !fifo_ne;
                end
            endcase
        end
        bus.mem_en    = gnt_rd || gnt_wr;
        bus.mem_we    = gnt_wr;
        bus.mem_addr  = gnt_wr ? fifo_addr[rptr] : bus.rd_addr;
        bus.mem_wdata = gnt_wr ? fifo_data[rptr] : '0;
        bus.rd_deny   = rst_n && bus.rd_req && !gnt_rd;
    end

    assign fifo_ne    = (count != '0);
    assign push       = bus.wr_req && wr_ready_q;
    assign pop        = gnt_wr;
    assign count_next = count + CNT_W'(push) - CNT_W'(pop);

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wptr] <= bus.wr_addr;
            fifo_data[wptr] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr       <= '0;
            rptr       <= '0;
            count      <= '0;
            wr_ready_q <= 1'b1;
        end else begin
            if (push) wptr <= wptr + PTR_W'(1);
            if (pop)  rptr <= rptr + PTR_W'(1);
            count      <= count_next;
            wr_ready_q <= (count_next != CNT_W'(FIFO_DEPTH));
        end
    end

    assign bus.wr_ready = wr_ready_q;

    // RAM returns data the cycle after the grant; it is registered once more before the strobe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_pend    <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_pend    <= gnt_rd;
            rd_valid_q <= rd_pend;
            if (rd_pend) rd_data_q <= bus.mem_rdata;
        end
    end

    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_data  = rd_data_q;

`ifdef ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_deny_cnt  <= '0;
            wr_stall_cnt <= '0;
        end else begin
            if (bus.rd_deny && rd_deny_cnt != 16'hFFFF)
                rd_deny_cnt <= rd_deny_cnt + 16'd1;
            if (bus.wr_req && !wr_ready_q && wr_stall_cnt != 16'hFFFF)
                wr_stall_cnt <= wr_stall_cnt + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_vga_mem_arbiter.sv
// Bench for vga_mem_arbiter: directed table, hand sequences and random traffic against a queue-based model.
module tb_vga_mem_arbiter;
    localparam int AW = 10;
    localparam int DW = 4;
    localparam int D  = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vga_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

`ifdef ARB_STATS_EN
    logic [15:0] rd_deny_cnt, wr_stall_cnt;
`endif

    vga_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(D)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
`ifdef ARB_STATS_EN
        ,
        .rd_deny_cnt(rd_deny_cnt),
        .wr_stall_cnt(wr_stall_cnt)
`endif
    );

    // Sample RAM: unwritten locations read a fixed pattern (address 5 holds 4'hA).
    function automatic logic [3:0] ram_init(input logic [9:0] a);
        return (a[3:0] + 4'd5) ^ a[7:4];
    endfunction

    logic [3:0] ram    [1024];
    bit         ram_wr [1024];
    always @(posedge clk) begin
        if (bus.mem_en === 1'b1) begin
            if (bus.mem_we) begin
                ram[bus.mem_addr]    <= bus.mem_wdata;
                ram_wr[bus.mem_addr] <= 1'b1;
            end else begin
                bus.mem_rdata <= ram_wr[bus.mem_addr] ? ram[bus.mem_addr] : ram_init(bus.mem_addr);
            end
        end
    end

    // Reference model
    typedef struct { logic [9:0] a; logic [3:0] d; } wr_t;
    typedef struct { int due; logic [3:0] d; } rd_t;
    wr_t        q[$];
    rd_t        sched[$];
    logic [3:0] shadow [1024];
    bit         m_disp, m_ready;
    logic [3:0] m_last;
    int         m_deny, m_stall;
    int         cyc;
    int         n_chk, n_pass;

    logic       s_en, s_we, s_deny, s_ready, s_rv;
    logic [9:0] s_addr;
    logic [3:0] s_rdata;

    typedef struct {
        bit h, rr; logic [9:0] ra;
        bit wq; logic [9:0] wa; logic [3:0] wd;
        bit e_en, e_we, e_deny, e_ready;
    } vec_t;
    vec_t tbl [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    endtask

    task automatic step(input bit h, input bit rr, input logic [9:0] ra,
                        input bit wq, input logic [9:0] wa, input logic [3:0] wd, input bit rst);
        bit e_rd, e_wr, e_deny, e_rv, push;
        bus.h_display = h;
        bus.rd_req    = rr;
        bus.rd_addr   = ra;
        bus.wr_req    = wq;
        bus.wr_addr   = wa;
        bus.wr_data   = wd;
        rst_n         = !rst;
        #1;
        s_en = bus.mem_en; s_we = bus.mem_we; s_deny = bus.rd_deny; s_ready = bus.wr_ready;
        s_rv = bus.rd_valid; s_addr = bus.mem_addr; s_rdata = bus.rd_data;

        e_rd = 1'b0; e_wr = 1'b0; e_rv = 1'b0;
        if (!rst) begin
            if (m_disp) begin
                e_rd = rr;
                e_wr = !rr && q.size() > 0;
            end else begin
                e_wr = q.size() > 0;
                e_rd = rr && q.size() == 0;
            end
        end
        e_deny = !rst && rr && !e_rd;
        chk("mem_en", 32'(bus.mem_en), 32'(e_rd | e_wr));
        chk("rd_deny", 32'(bus.rd_deny), 32'(e_deny));
        if (!rst) begin
            chk("mem_we", 32'(bus.mem_we), 32'(e_wr));
            if (e_rd) chk("mem_addr_rd", 32'(bus.mem_addr), 32'(ra));
            if (e_wr) begin
                chk("mem_addr_wr", 32'(bus.mem_addr), 32'(q[0].a));
                chk("mem_wdata", 32'(bus.mem_wdata), 32'(q[0].d));
            end
            chk("wr_ready", 32'(bus.wr_ready), 32'(m_ready));
            e_rv = sched.size() > 0 && sched[0].due == cyc;
            if (e_rv) m_last = sched[0].d;
            chk("rd_valid", 32'(bus.rd_valid), 32'(e_rv));
            chk("rd_data", 32'(bus.rd_data), 32'(m_last));
`ifdef ARB_STATS_EN
            chk("rd_deny_cnt", 32'(rd_deny_cnt), 32'(m_deny));
            chk("wr_stall_cnt", 32'(wr_stall_cnt), 32'(m_stall));
`endif
        end

        if (rst) begin
            q.delete();
            sched.delete();
            m_disp = 1'b0; m_ready = 1'b1; m_last = '0; m_deny = 0; m_stall = 0;
        end else begin
            push = wq && m_ready;
            if (e_rv) void'(sched.pop_front());
            if (wq && !m_ready && m_stall < 65535) m_stall++;
            if (e_deny && m_deny < 65535) m_deny++;
            if (e_rd) sched.push_back('{cyc + 2, shadow[ra]});
            if (e_wr) begin
                shadow[q[0].a] = q[0].d;
                void'(q.pop_front());
            end
            if (push) q.push_back('{wa, wd});
            m_ready = (q.size() != D);
            m_disp  = h;
        end
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        int nwr;
        bit h_r;
        n_chk = 0; n_pass = 0; cyc = 0;
        for (int i = 0; i < 1024; i++) shadow[i] = ram_init(10'(i));

        // h | rr | ra | wq | wa | wd || en we deny ready
        tbl[0]  = '{1, 1, 10'h020, 1, 10'h100, 4'h1, 1, 0, 0, 1};
        tbl[1]  = '{1, 1, 10'h021, 1, 10'h101, 4'h2, 1, 0, 0, 1};
        tbl[2]  = '{1, 1, 10'h022, 1, 10'h102, 4'h3, 1, 0, 0, 1};
        tbl[3]  = '{1, 1, 10'h023, 1, 10'h103, 4'h4, 1, 0, 0, 1};
        tbl[4]  = '{1, 1, 10'h024, 1, 10'h104, 4'h5, 1, 0, 0, 0};
        tbl[5]  = '{0, 1, 10'h025, 0, 10'h000, 4'h0, 1, 0, 0, 0};
        tbl[6]  = '{0, 1, 10'h026, 0, 10'h000, 4'h0, 1, 1, 1, 0};
        tbl[7]  = '{0, 1, 10'h027, 0, 10'h000, 4'h0, 1, 1, 1, 1};
        tbl[8]  = '{0, 1, 10'h028, 0, 10'h000, 4'h0, 1, 1, 1, 1};
        tbl[9]  = '{0, 1, 10'h029, 0, 10'h000, 4'h0, 1, 1, 1, 1};
        tbl[10] = '{0, 1, 10'h02A, 0, 10'h000, 4'h0, 1, 0, 0, 1};

        bus.h_display = 0; bus.rd_req = 0; bus.rd_addr = '0;
        bus.wr_req = 0; bus.wr_addr = '0; bus.wr_data = '0;
        @(negedge clk);

        // Reset for two cycles, then idle
        step(0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("reset_mem_en", 32'(s_en), 32'd0);
        chk("reset_rd_valid", 32'(s_rv), 32'd0);
        chk("reset_wr_ready", 32'(s_ready), 32'd1);

        // Display read of address 5
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 1, 10'h005, 0, 0, 0, 0);
        chk("disp_rd_en", 32'(s_en), 32'd1);
        chk("disp_rd_we", 32'(s_we), 32'd0);
        chk("disp_rd_addr", 32'(s_addr), 32'h005);
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        chk("disp_rd_valid", 32'(s_rv), 32'd1);
        chk("disp_rd_data", 32'(s_rdata), 32'hA);

        // Display contention then blanking drain
        for (int i = 0; i < 11; i++) begin
            step(tbl[i].h, tbl[i].rr, tbl[i].ra, tbl[i].wq, tbl[i].wa, tbl[i].wd, 0);
            chk($sformatf("tbl%0d_en", i), 32'(s_en), 32'(tbl[i].e_en));
            chk($sformatf("tbl%0d_we", i), 32'(s_we), 32'(tbl[i].e_we));
            chk($sformatf("tbl%0d_deny", i), 32'(s_deny), 32'(tbl[i].e_deny));
            chk($sformatf("tbl%0d_ready", i), 32'(s_ready), 32'(tbl[i].e_ready));
            if (i >= 6 && i <= 9) chk($sformatf("tbl%0d_waddr", i), 32'(s_addr), 32'(10'h100 + 10'(i - 6)));
        end
`ifdef ARB_STATS_EN
        chk("stats_deny", 32'(rd_deny_cnt), 32'd4);
        chk("stats_stall", 32'(wr_stall_cnt), 32'd1);
`endif

        // Fill the FIFO during the line, then hold wr_req through blanking
        for (int i = 0; i < 4; i++) step(1, 1, 10'h030, 1, 10'h200 + 10'(i), 4'(i + 6), 0);
        nwr = 0;
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 0, 1, 10'h210 + 10'(i), 4'(i), 0);
            if (s_en && s_we) nwr++;
        end
        chk("full_fifo_writes", 32'(nwr), 32'd10);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 0, 0);

        // Reset with writes pending and a read in flight
        for (int i = 0; i < 3; i++) step(1, 1, 10'h040, 1, 10'h300 + 10'(i), 4'hF, 0);
        step(1, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("midrst_mem_en", 32'(s_en), 32'd0);
        chk("midrst_rd_valid", 32'(s_rv), 32'd0);
        chk("midrst_wr_ready", 32'(s_ready), 32'd1);

        // Random traffic
        h_r = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) h_r = !h_r;
            step(h_r, bit'($urandom_range(0, 1)), 10'($urandom_range(0, 31)),
                 $urandom_range(0, 9) < 6, 10'($urandom_range(0, 31)), 4'($urandom),
                 $urandom_range(0, 299) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
